// File: rtl/expu_arbiter.sv
// Round-robin arbiter sharing one EXPU among N_REQ requesters; burst lock on last, tag-routed returns, drain/clear flush.
// Zero added latency in both directions; backpressure passes through combinationally (a stalled requester stalls the EXPU pipe).
module expu_arbiter #(
  parameter  int N_REQ           = 2,
  parameter  int N_ROWS          = 1,
  parameter  int WIDTH           = 16,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int ID_W            = $clog2(N_REQ)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic [N_REQ-1:0]                         req_valid_i,
  output logic [N_REQ-1:0]                         req_ready_o,
  input  logic [N_REQ-1:0]                         req_last_i,
  input  logic [N_REQ-1:0][N_ROWS-1:0][WIDTH-1:0]  req_op_i,
  input  logic [N_REQ-1:0][N_ROWS-1:0]             req_strb_i,
  output logic [N_REQ-1:0]                         rsp_valid_o,
  input  logic [N_REQ-1:0]                         rsp_ready_i,
  output logic [N_ROWS-1:0][WIDTH-1:0]             rsp_res_o,
  output logic [N_ROWS-1:0]                        rsp_strb_o,
  output logic                                     expu_valid_o,
  input  logic                                     expu_ready_i,
  output logic [N_ROWS-1:0][WIDTH-1:0]             expu_op_o,
  output logic [N_ROWS-1:0]                        expu_strb_o,
  output logic [ID_W-1:0]                          expu_tag_o,
  input  logic                                     expu_valid_i,
  output logic                                     expu_ready_o,
  input  logic [N_ROWS-1:0][WIDTH-1:0]             expu_res_i,
  input  logic [N_ROWS-1:0]                        expu_strb_i,
  input  logic [ID_W-1:0]                          expu_tag_i,
  input  logic                                     expu_busy_i,
  output logic                                     expu_enable_o,
  output logic                                     expu_clear_o,
  output logic                                     flush_done_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN, CLEAR} state_t;

  state_t                        state_q, state_d;
  logic [ID_W-1:0]               rr_q, rr_d;
  logic [ID_W-1:0]               owner_q, owner_d;
  logic                          flush_pend_q, flush_pend_d;
  logic [N_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]              elig;
  logic                          gnt_vld;
  logic [ID_W-1:0]               gnt_id;
  logic                          xfer;
  logic                          rsp_hs;
  int                            idx;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Grants are withheld during reset and as soon as a flush is pending.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      elig[k] = req_valid_i[k] && (cnt_q[k] < CNT_W'(MAX_OUTSTANDING));
    end
    if (!rst_i && !flush_pend_q) begin
      if (state_q == IDLE) begin
        for (int i = 0; i < N_REQ; i++) begin
          idx = int'(rr_q) + i;
          if (idx >= N_REQ) idx = idx - N_REQ;
          if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'(idx);
          end
        end
      end else if (state_q == LOCKED && elig[owner_q]) begin
        gnt_vld = 1'b1;
        gnt_id  = owner_q;
      end
    end
  end

  assign expu_valid_o = gnt_vld;
  assign expu_op_o    = req_op_i[gnt_id];
  assign expu_strb_o  = req_strb_i[gnt_id];
  assign expu_tag_o   = gnt_id;
  assign xfer         = gnt_vld & expu_ready_i;

  assign rsp_res_o    = expu_res_i;
  assign rsp_strb_o   = expu_strb_i;
  assign expu_ready_o = ~expu_valid_i | rsp_ready_i[expu_tag_i];
  assign rsp_hs       = expu_valid_i & expu_ready_o;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_ready_o[k] = xfer && (gnt_id == ID_W'(k));
      rsp_valid_o[k] = expu_valid_i && (expu_tag_i == ID_W'(k));
      cnt_d[k]       = cnt_q[k];
      if (req_ready_o[k] && !(rsp_hs && rsp_valid_o[k])) cnt_d[k] = cnt_q[k] + CNT_W'(1);
      if (!req_ready_o[k] && (rsp_hs && rsp_valid_o[k])) cnt_d[k] = cnt_q[k] - CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    flush_pend_d = flush_pend_q | flush_i;
    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d = DRAIN;
        end else if (xfer) begin
          if (req_last_i[gnt_id]) begin
            rr_d = next_id(gnt_id);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_id;
          end
        end
      end
      LOCKED: begin
        if (flush_pend_q) begin
          state_d = DRAIN;
        end else if (xfer && req_last_i[owner_q]) begin
          state_d = IDLE;
          rr_d    = next_id(owner_q);
        end
      end
      DRAIN: begin
        if (cnt_q == '0 && !expu_busy_i) state_d = CLEAR;
      end
      CLEAR: begin
        state_d      = IDLE;
        rr_d         = '0;
        flush_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign expu_enable_o = ~rst_i;
  assign expu_clear_o  = (state_q == CLEAR);
  assign flush_done_o  = (state_q == CLEAR);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_hs |-> (cnt_q[expu_tag_i] != '0));

  generate
    if ((1 << ID_W) != N_REQ) begin : g_tag_chk
      a_tag_range: assert property (@(posedge clk_i) disable iff (rst_i)
        expu_valid_i |-> (int'(expu_tag_i) < N_REQ));
    end
  endgenerate

endmodule

// File: tb/tb_expu_arbiter.sv
// Randomised and directed bench for expu_arbiter; the bench itself plays the EXPU as an in-order result queue.
module tb_expu_arbiter;
  localparam int N_REQ  = 3;
  localparam int N_ROWS = 2;
  localparam int WIDTH  = 16;
  localparam int MAX    = 4;
  localparam int ID_W   = $clog2(N_REQ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                    rst_i, flush_i;
  logic [N_REQ-1:0]                        req_valid_i, req_ready_o, req_last_i;
  logic [N_REQ-1:0][N_ROWS-1:0][WIDTH-1:0] req_op_i;
  logic [N_REQ-1:0][N_ROWS-1:0]            req_strb_i;
  logic [N_REQ-1:0]                        rsp_valid_o, rsp_ready_i;
  logic [N_ROWS-1:0][WIDTH-1:0]            rsp_res_o, expu_op_o, expu_res_i;
  logic [N_ROWS-1:0]                       rsp_strb_o, expu_strb_o, expu_strb_i;
  logic                                    expu_valid_o, expu_ready_i, expu_valid_i, expu_ready_o;
  logic [ID_W-1:0]                         expu_tag_o, expu_tag_i;
  logic                                    expu_busy_i, expu_enable_o, expu_clear_o, flush_done_o;

  expu_arbiter #(.N_REQ(N_REQ), .N_ROWS(N_ROWS), .WIDTH(WIDTH), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_last_i(req_last_i),
    .req_op_i(req_op_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o), .rsp_strb_o(rsp_strb_o),
    .expu_valid_o(expu_valid_o), .expu_ready_i(expu_ready_i), .expu_op_o(expu_op_o),
    .expu_strb_o(expu_strb_o), .expu_tag_o(expu_tag_o),
    .expu_valid_i(expu_valid_i), .expu_ready_o(expu_ready_o), .expu_res_i(expu_res_i),
    .expu_strb_i(expu_strb_i), .expu_tag_i(expu_tag_i), .expu_busy_i(expu_busy_i),
    .expu_enable_o(expu_enable_o), .expu_clear_o(expu_clear_o), .flush_done_o(flush_done_o)
  );

  typedef struct {
    int                           tag;
    logic [N_ROWS-1:0][WIDTH-1:0] res;
    logic [N_ROWS-1:0]            strb;
  } beat_t;

  int    n_tests = 0, n_fail = 0;
  // Reference model: phase 0 = arbitrating, 1 = draining, 2 = clear cycle.
  int    m_cnt[N_REQ];
  int    m_owner, m_start, m_phase;
  bit    m_pend;
  beat_t pipe[$];
  int    xlog[$];
  int    rsp_cnt[N_REQ];
  int    clr_cycles;
  int    show;
  bit    held;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_REQ; k++) m_cnt[k] = 0;
    m_owner = -1; m_start = 0; m_phase = 0; m_pend = 0;
  endtask

  task automatic drive_expu();
    if (rst_i) begin
      pipe.delete();
      held = 0;
    end
    expu_valid_i = (pipe.size() > 0) &&
                   (show == 1 || (show == 2 && (held || $urandom_range(3) != 0)));
    if (pipe.size() > 0) begin
      expu_tag_i  = ID_W'(pipe[0].tag);
      expu_res_i  = pipe[0].res;
      expu_strb_i = pipe[0].strb;
    end else begin
      expu_tag_i  = '0;
      expu_res_i  = {N_ROWS{16'hDEAD}};
      expu_strb_i = '0;
    end
    expu_busy_i = (pipe.size() != 0);
  endtask

  task automatic eval();
    bit               g_vld, xfer, hs, all0;
    int               g, k, tg;
    logic [N_REQ-1:0] e_rdy, e_rsp;
    beat_t            b;
    g_vld = 0; g = 0;
    if (!rst_i && m_phase == 0 && !m_pend) begin
      if (m_owner >= 0) begin
        if (req_valid_i[m_owner] && m_cnt[m_owner] < MAX) begin g_vld = 1; g = m_owner; end
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          k = (m_start + i) % N_REQ;
          if (!g_vld && req_valid_i[k] && m_cnt[k] < MAX) begin g_vld = 1; g = k; end
        end
      end
    end
    xfer  = g_vld && expu_ready_i;
    e_rdy = '0;
    if (xfer) e_rdy[g] = 1'b1;
    chk("expu_valid", expu_valid_o, g_vld);
    chk("req_ready", req_ready_o, e_rdy);
    if (g_vld) begin
      chk("expu_tag", expu_tag_o, g);
      chk("expu_op", expu_op_o, req_op_i[g]);
      chk("expu_strb", expu_strb_o, req_strb_i[g]);
    end
    e_rsp = '0;
    tg    = int'(expu_tag_i);
    if (expu_valid_i) e_rsp[tg] = 1'b1;
    hs = expu_valid_i && rsp_ready_i[tg];
    chk("rsp_valid", rsp_valid_o, e_rsp);
    chk("expu_ready_o", expu_ready_o, !expu_valid_i || rsp_ready_i[tg]);
    if (expu_valid_i) begin
      chk("rsp_res", rsp_res_o, pipe[0].res);
      chk("rsp_strb", rsp_strb_o, pipe[0].strb);
    end
    chk("clear", expu_clear_o, m_phase == 2);
    chk("flush_done", flush_done_o, m_phase == 2);
    chk("enable", expu_enable_o, !rst_i);
    if (expu_clear_o) clr_cycles++;

    if (hs) begin
      rsp_cnt[tg]++;
      void'(pipe.pop_front());
    end
    held = expu_valid_i && !hs;
    if (xfer) begin
      xlog.push_back(g);
      b.tag = g;
      for (int r = 0; r < N_ROWS; r++) b.res[r] = req_op_i[g][r] ^ 16'h3C3C;
      b.strb = req_strb_i[g];
      pipe.push_back(b);
    end

    if (rst_i) begin
      model_reset();
    end else begin
      all0 = 1;
      for (int j = 0; j < N_REQ; j++) if (m_cnt[j] != 0) all0 = 0;
      if (xfer) m_cnt[g]++;
      if (hs) m_cnt[tg]--;
      if (m_phase == 2) begin
        m_phase = 0; m_start = 0; m_pend = 0; m_owner = -1;
      end else begin
        if (m_phase == 1) begin
          if (all0 && !expu_busy_i) m_phase = 2;
        end else if (m_pend) begin
          m_phase = 1; m_owner = -1;
        end else if (xfer) begin
          if (req_last_i[g]) begin m_owner = -1; m_start = (g + 1) % N_REQ; end
          else m_owner = g;
        end
        if (flush_i) m_pend = 1;
      end
    end
  endtask

  task automatic step();
    drive_expu();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < N_REQ; k++) begin
      for (int r = 0; r < N_ROWS; r++) req_op_i[k][r] = WIDTH'($urandom);
      req_strb_i[k] = N_ROWS'($urandom);
    end
  endtask

  task automatic drain(input string nm);
    req_valid_i = '0; rsp_ready_i = '1; expu_ready_i = 1'b1; show = 1; flush_i = 1'b0;
    for (int c = 0; c < 100 && pipe.size() > 0; c++) step();
    step();
    chk(nm, pipe.size(), 0);
  endtask

  int exp1[6] = '{0, 1, 0, 1, 0, 1};
  int exp2[5] = '{0, 0, 0, 0, 1};

  initial begin
    int n0, base;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '1; req_last_i = '1;
    rsp_ready_i = '0; expu_ready_i = 1'b1; show = 0; held = 0; clr_cycles = 0;
    for (int k = 0; k < N_REQ; k++) rsp_cnt[k] = 0;
    model_reset();
    randomize_data();
    @(posedge clk); #1;
    step(); step(); step();
    chk("reset_ready", req_ready_o, 0);
    chk("reset_enable", expu_enable_o, 0);
    rst_i = 1'b0;

    // Alternating single-beat grants between requesters 0 and 1.
    xlog.delete();
    req_valid_i = 3'b011; req_last_i = '1;
    for (int i = 0; i < 6; i++) begin randomize_data(); step(); end
    chk("alt_count", xlog.size(), 6);
    for (int i = 0; i < 6 && i < xlog.size(); i++) chk("alt_grant", xlog[i], exp1[i]);
    drain("alt_drain");
    chk("alt_rsp0", rsp_cnt[0], 3);
    chk("alt_rsp1", rsp_cnt[1], 3);

    // Burst lock: requester 0 sends four beats while requester 1 waits.
    xlog.delete();
    req_valid_i = 3'b011;
    for (int c = 0; c < 20 && xlog.size() < 5; c++) begin
      n0 = 0;
      foreach (xlog[i]) if (xlog[i] == 0) n0++;
      req_last_i = {2'b11, n0 == 3};
      randomize_data();
      step();
    end
    chk("burst_count", xlog.size(), 5);
    for (int i = 0; i < 5 && i < xlog.size(); i++) chk("burst_grant", xlog[i], exp2[i]);
    drain("burst_drain");

    // Same-cycle transfer and response at count 1, then saturation.
    xlog.delete();
    req_valid_i = 3'b001; req_last_i = '1;
    step();
    step();
    rsp_ready_i = 3'b110;
    for (int i = 0; i < 8; i++) begin randomize_data(); step(); end
    chk("sat_count", xlog.size(), 2 + MAX - 1);
    chk("sat_ready0", req_ready_o[0], 0);
    req_valid_i = 3'b011; expu_ready_i = 1'b0;
    step();
    chk("stall_ready", req_ready_o, 0);
    chk("stall_expu_ready", expu_ready_o, 0);
    drain("sat_drain");

    // Flush mid-burst with three beats in flight.
    xlog.delete(); clr_cycles = 0;
    show = 0; req_valid_i = 3'b001; req_last_i = 3'b110;
    for (int c = 0; c < 20 && xlog.size() < 2; c++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_inflight", xlog.size(), 3);
    req_valid_i = 3'b011;
    for (int i = 0; i < 5; i++) begin flush_i = (i == 2); step(); end
    flush_i = 1'b0;
    chk("flush_nogrant", xlog.size(), 3);
    chk("flush_noclear_yet", clr_cycles, 0);
    show = 1; req_last_i = '1;
    for (int c = 0; c < 50 && clr_cycles == 0; c++) step();
    chk("flush_clear_seen", clr_cycles, 1);
    xlog.delete();
    for (int i = 0; i < 3; i++) step();
    chk("flush_clear_once", clr_cycles, 1);
    chk("post_flush_grant", (xlog.size() > 0) ? xlog[0] : -1, 0);
    drain("flush_drain");

    // Reset while requester 0 is mid-burst with three outstanding.
    xlog.delete();
    show = 0; req_valid_i = 3'b001; req_last_i = 3'b110; rsp_ready_i = '0;
    for (int c = 0; c < 20 && xlog.size() < 3; c++) step();
    rst_i = 1'b1;
    step(); step();
    chk("midrst_ready", req_ready_o, 0);
    rst_i = 1'b0;
    xlog.delete();
    req_last_i = '1; rsp_ready_i = 3'b110; show = 1;
    for (int i = 0; i < 8; i++) step();
    chk("midrst_cnt_cleared", xlog.size(), MAX);
    drain("midrst_drain");

    // Randomised traffic.
    show = 2;
    base = n_fail;
    for (int c = 0; c < 3000; c++) begin
      req_valid_i  = N_REQ'($urandom);
      req_last_i   = N_REQ'($urandom | $urandom);
      rsp_ready_i  = N_REQ'($urandom | $urandom);
      expu_ready_i = ($urandom_range(3) != 0);
      flush_i      = ($urandom_range(79) == 0);
      randomize_data();
      step();
    end
    drain("final_drain");
    if (n_fail != base) $display("random phase saw %0d errors", n_fail - base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
